// File: rtl/rsa_precomp.sv
// Montgomery precomputation: R = 2^N mod M, R2 = 2^(2N) mod M by repeated modular doubling,
// plus the bit length of E. Define RSA_PRECOMP_CACHE_EN to skip the doubling when M repeats.
module rsa_precomp #(
    parameter int N    = 1024,
    parameter int LENW = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [N-1:0]    in_m,
    input  logic [N-1:0]    in_e,
    output logic [N-1:0]    out_r,
    output logic [N-1:0]    out_r2,
    output logic [LENW-1:0] lene,
    output logic            busy,
    output logic            done
);
    localparam int SW = $clog2(2 * N + 1);
    localparam logic [SW-1:0] STEP_N  = SW'(N);
    localparam logic [SW-1:0] STEP_2N = SW'(2 * N);

    typedef enum logic [1:0] {IDLE, INIT, DBL, FIN} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    m_q, m_d;
    logic [N-1:0]    e_q, e_d;
    logic [N-1:0]    v_q, v_d;
    logic [SW-1:0]   step_q, step_d;
    logic            found_q, found_d;
    logic [LENW-1:0] lene_q, lene_d;
    logic [N-1:0]    r_q, r_d;
    logic [N-1:0]    r2_q, r2_d;
    logic            done_q, done_d;
    logic            run_hit;

`ifdef RSA_PRECOMP_CACHE_EN
    logic [N-1:0] last_m_q, last_m_d;
    logic         cache_valid_q, cache_valid_d;
    logic         hit_q, hit_d;
    assign run_hit = hit_q;
`else
    assign run_hit = 1'b0;
`endif

    // v stays below M, so N bits suffice; with M=0 the wrap to zero yields the required 0 result.
    logic [N:0]    t;
    logic [N-1:0]  v_next;
    logic [SW-1:0] step_inc;

    always_comb begin
        // NOTE: every next-state variable gets its hold value first so no latch is inferred.
        state_d  = state_q;
        m_d      = m_q;
        e_d      = e_q;
        v_d      = v_q;
        step_d   = step_q;
        found_d  = found_q;
        lene_d   = lene_q;
        r_d      = r_q;
        r2_d     = r2_q;
        done_d   = 1'b0;
`ifdef RSA_PRECOMP_CACHE_EN
        last_m_d      = last_m_q;
        cache_valid_d = cache_valid_q;
        hit_d         = hit_q;
`endif
        t        = {v_q, 1'b0};
        v_next   = (t >= {1'b0, m_q}) ? N'(t - {1'b0, m_q}) : N'(t);
        step_inc = step_q + 1'b1;

        unique case (state_q)
            IDLE: if (start) state_d = INIT;
            INIT: begin
                m_d     = in_m;
                e_d     = in_e;
                // Seeding with 1 mod M keeps the M=1 case at the correct residue of 0.
                v_d     = (in_m == N'(1)) ? '0 : N'(1);
                step_d  = '0;
                found_d = 1'b0;
                lene_d  = '0;
`ifdef RSA_PRECOMP_CACHE_EN
                hit_d   = cache_valid_q && (in_m == last_m_q);
`endif
                state_d = DBL;
            end
            DBL: begin
                step_d = step_inc;
                if (step_q < STEP_N) begin
                    e_d = e_q << 1;
                    if (!found_q && e_q[N-1]) begin
                        found_d = 1'b1;
                        lene_d  = LENW'(N) - LENW'(step_q);
                    end
                end
                if (run_hit) begin
                    if (step_inc == STEP_N) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end
                end else begin
                    v_d = v_next;
                    if (step_inc == STEP_N) r_d = v_next;
                    if (step_inc == STEP_2N) begin
                        r2_d    = v_next;
                        state_d = FIN;
                        done_d  = 1'b1;
                    end
                end
            end
            FIN: begin
`ifdef RSA_PRECOMP_CACHE_EN
                if (!hit_q) begin
                    last_m_d      = m_q;
                    cache_valid_d = 1'b1;
                end
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            m_q     <= '0;
            e_q     <= '0;
            v_q     <= '0;
            step_q  <= '0;
            found_q <= 1'b0;
            lene_q  <= '0;
            r_q     <= '0;
            r2_q    <= '0;
            done_q  <= 1'b0;
`ifdef RSA_PRECOMP_CACHE_EN
            last_m_q      <= '0;
            cache_valid_q <= 1'b0;
            hit_q         <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            e_q     <= e_d;
            v_q     <= v_d;
            step_q  <= step_d;
            found_q <= found_d;
            lene_q  <= lene_d;
            r_q     <= r_d;
            r2_q    <= r2_d;
            done_q  <= done_d;
`ifdef RSA_PRECOMP_CACHE_EN
            last_m_q      <= last_m_d;
            cache_valid_q <= cache_valid_d;
            hit_q         <= hit_d;
`endif
        end
    end

    assign out_r  = r_q;
    assign out_r2 = r2_q;
    assign lene   = lene_q;
    assign busy   = (state_q != IDLE);
    assign done   = done_q;
endmodule

// File: tb/tb_rsa_precomp.sv
// Scoreboard bench for rsa_precomp: expected R, R2, bit length and latency are derived
// from wide-integer arithmetic and queued at start, then compared when done pulses.
module tb_rsa_precomp;
    localparam int N    = 1024;
    localparam int LENW = 32;
`ifdef RSA_PRECOMP_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [N-1:0]    in_m, in_e;
    logic [N-1:0]    out_r, out_r2;
    logic [LENW-1:0] lene;
    logic            busy, done;

    typedef struct {
        logic [N-1:0]    r;
        logic [N-1:0]    r2;
        logic [LENW-1:0] len;
        int              lat;
    } exp_t;

    exp_t         sb[$];
    int           checks   = 0;
    int           failures = 0;
    bit           tb_valid = 1'b0;
    logic [N-1:0] tb_last_m = '0;

    rsa_precomp #(.N(N), .LENW(LENW)) dut (
        .clk(clk), .reset(reset), .start(start), .in_m(in_m), .in_e(in_e),
        .out_r(out_r), .out_r2(out_r2), .lene(lene), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] pow2_mod(input logic [N-1:0] m, input int k);
        logic [2*N:0] p;
        logic [2*N:0] mm;
        if (m == '0) return '0;
        p  = '0;
        p[k] = 1'b1;
        mm = {{(N+1){1'b0}}, m};
        return N'(p % mm);
    endfunction

    function automatic logic [LENW-1:0] bit_len(input logic [N-1:0] e);
        for (int i = N - 1; i >= 0; i--) if (e[i]) return LENW'(i + 1);
        return '0;
    endfunction

    function automatic logic [N-1:0] rand_wide();
        logic [N-1:0] x;
        for (int i = 0; i < N / 32; i++) x[i*32 +: 32] = $urandom;
        return x;
    endfunction

    // Drives one run; extra_at > 0 pulses start again while busy at that cycle.
    task automatic run(input logic [N-1:0] m, input logic [N-1:0] e, input int extra_at,
                       input string name);
        exp_t x, got;
        int   cyc;
        bit   hit;
        hit   = CACHE && tb_valid && (m == tb_last_m);
        x.r   = pow2_mod(m, N);
        x.r2  = pow2_mod(m, 2 * N);
        x.len = bit_len(e);
        x.lat = hit ? N + 2 : 2 * N + 2;
        sb.push_back(x);
        in_m  = m;
        in_e  = e;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        while (cyc < 3 * N) begin
            @(posedge clk);
            cyc++;
            #1;
            if (cyc == 3) begin
                in_m = rand_wide();
                in_e = rand_wide();
            end
            start = (extra_at > 0 && cyc == extra_at - 1);
            if (done) break;
        end
        start = 1'b0;
        got = sb.pop_front();
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s timeout: no done within %0d cycles", name, cyc);
        end else if (cyc + 1 !== got.lat) begin
            failures++;
            $display("FAIL %s latency: got %0d expected %0d", name, cyc + 1, got.lat);
        end
        checks++;
        if (out_r !== got.r) begin
            failures++;
            $display("FAIL %s out_r: got %0h expected %0h", name, out_r[63:0], got.r[63:0]);
        end
        checks++;
        if (out_r2 !== got.r2) begin
            failures++;
            $display("FAIL %s out_r2: got %0h expected %0h", name, out_r2[63:0], got.r2[63:0]);
        end
        checks++;
        if (lene !== got.len) begin
            failures++;
            $display("FAIL %s lene: got %0d expected %0d", name, lene, got.len);
        end
        if (!hit) begin
            tb_valid  = 1'b1;
            tb_last_m = m;
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s pulse: done=%b busy=%b expected 0 0", name, done, busy);
        end
        checks++;
        if (out_r !== got.r || lene !== got.len) begin
            failures++;
            $display("FAIL %s hold: out_r=%0h lene=%0d expected %0h %0d", name,
                     out_r[63:0], lene, got.r[63:0], got.len);
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out_r !== '0 || out_r2 !== '0 || lene !== '0) begin
            failures++;
            $display("FAIL %s: busy=%b done=%b out_r=%0h out_r2=%0h lene=%0d expected all 0",
                     name, busy, done, out_r[63:0], out_r2[63:0], lene);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        in_m  = N'(7);
        in_e  = N'(1);
        repeat (3) @(posedge clk);
        #1 start = 1'b0;
        check_zero("reset_state");
        reset = 1'b0;
        @(posedge clk);
        #1 check_zero("reset_start_priority");
        tb_valid = 1'b0;
    endtask

    task automatic test_basic();
        logic [N-1:0] m, e;
        run(N'(7), N'(1), 0, "m7_e1");
        m = '0; m[N-1] = 1'b1; m[0] = 1'b1;
        e = '0; e[N-1] = 1'b1;
        run(m, e, 0, "m_top_plus1");
    endtask

    task automatic test_back_to_back();
        run(N'(3), N'(32'h10001), 0, "m3");
        run(N'(5), N'(32'h10001), 0, "m5");
    endtask

    task automatic test_ignored_start();
        run(N'(7), N'(0), 100, "e0_restart");
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL ignored_start: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_edges();
        logic [N-1:0] m;
        run(N'(0), rand_wide(), 0, "m0");
        run(N'(1), N'(32'h80), 0, "m1");
        for (int i = 0; i < 2; i++) begin
            m = rand_wide();
            m[0] = 1'b1;
            run(m, rand_wide() >> (i * 300), 0, "random");
        end
    endtask

    task automatic test_cache();
        run(N'(7), N'(5), 0, "cache_first");
        run(N'(7), N'(3), 0, "cache_second");
    endtask

    task automatic test_abort();
        int seen;
        in_m  = N'(11);
        in_e  = N'(1);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (1499) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        tb_valid = 1'b0;
        check_zero("abort_reset");
        seen = 0;
        repeat (2 * N + 10) begin
            @(posedge clk);
            #1 if (done) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL abort_no_done: got %0d done pulses expected 0", seen);
        end
        run(N'(7), N'(1), 0, "after_abort");
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        in_m  = '0;
        in_e  = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_ignored_start();
        test_edges();
        test_cache();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
